pbus_mailbox: RTL and testbench
===============================

# pbus_mailbox

Host mailbox stage between the PBus `interface` block and the application `main` logic. It decodes the host's RD/WR strobes and word address into a small register map: a host-to-application FIFO, an application-to-host FIFO, a status/sticky-error register and a scratch register. It turns the host's level-style bus transactions into single-cycle push/pop events. It also presents valid/ready streams to the application.

## Interface
- DataWidth, 32, host and FIFO data width (`GlobalDataWidth`)
- AddrWidth, `GlobalAddrWidth`, host word-address width
- DepthLog2, 4, log2 of each FIFO depth; range 1..7
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  asynchronous, active-high reset; clears all state
- RD  in  1  host read level from `interface`; also the PBus output-buffer enable
- WR  in  1  host write level from `interface`
- Addr  in  AddrWidth  host word address, stable while RD or WR is high
- DataIn  in  DataWidth  host write data, stable while WR is high
- DataOut  out  DataWidth  host read data, registered
- AppInData  out  DataWidth  head of the host-to-app FIFO
- AppInValid  out  1  host-to-app FIFO not empty
- AppInReady  in  1  app pops the host-to-app FIFO when Valid&Ready
- AppOutData  in  DataWidth  app result word
- AppOutValid  in  1  app pushes to the app-to-host FIFO when Valid&Ready
- AppOutReady  out  1  app-to-host FIFO not full

## Operation
- Decode: only Addr[1:0] is significant, and only when Addr[AddrWidth-1:2]==0. Any other address reads 0 and ignores writes.
- Map:
  - 0 IN: write pushes DataIn; read returns 0.
  - 1 OUT: read returns the FIFO head and pops it; write is ignored.
  - 2 STATUS: read returns bit31 overflow, bit30 underflow, [15:8] out count, [7:0] in count, all other bits 0. A write clears each sticky bit whose DataIn bit is 1.
  - 3 SCRATCH: read/write DataWidth register.
- Transactions: RD and WR are levels held for at least 2 Clk cycles and are never high together.
  - Write action: taken once, in the first cycle WR is seen high (rising edge of registered WR).
  - Read: Addr is latched on the RD rise. The pop for OUT happens in the first cycle RD is seen low after a latched read (read-armed flag), so the host samples data before the FIFO advances.
- Edge detection: the previous-strobe registers reset to 1 and the armed flag resets to 0. A strobe held high across reset release therefore causes no action.
- Host push to a full IN FIFO: the word is dropped and overflow is set. Fullness is evaluated at the start of the cycle. An app pop in the same cycle still occurs.
- Host pop of an empty OUT FIFO: DataOut is 0, underflow is set, and no pointer moves.
- Simultaneous push and pop on the same FIFO: both happen and the count is unchanged. Pointers wrap modulo 2^DepthLog2. The count is DepthLog2+1 bits, zero-extended into the status fields.
- Sticky bits: set has priority over a clear in the same cycle.

## Timing
- Reset values:
  - DataOut: 0
  - AppInValid: 0
  - AppOutReady: 1
  - FIFOs: empty
  - Sticky bits: 0
  - Scratch: 0
- DataOut update: while RD is high, DataOut(t+1) = decode(Addr(t), state(t)). While RD is low, DataOut = 0.
- DataOut validity: valid from the 2nd RD-high cycle onward.
- Host push: AppInValid rises 1 cycle after the WR-rise cycle, and the status count reflects the push 1 cycle after.
- App push: the word is readable at OUT on the next host read. AppOutReady falls in the cycle after the push that fills the FIFO.
- Pop of OUT: occurs on the RD-fall cycle. The status count updates in the following cycle.
- Reset asserted mid-transaction: the transaction is aborted and no push or pop is completed.

## Structure
- Package `mailbox_pkg`:
  - address constants MB_IN=0, MB_OUT=1, MB_STATUS=2, MB_SCRATCH=3
  - status bit positions OVF=31, UNF=30
  - count field offsets 0 and 8
- Sub-module `sync_fifo` (DataWidth, DepthLog2):
  - ports push, pop, din, dout, count, full, empty
  - first-word-fall-through
  - instantiated twice
- Top level: strobe edge detection, read-armed flag, address latch, decode mux, sticky register and scratch register.

## Test plan
- Reset, then write 0xDEADBEEF to SCRATCH and read it back -> DataOut=0xDEADBEEF from the 2nd RD cycle. Read STATUS -> 0x00000000.
- Write 16 words 1..16 to IN with AppInReady=0 -> status in count=16 (0x00000010). A 17th write -> bit31 set, count stays 16. App pops 16 words -> 1..16 in order.
- App pushes 0xA5A5A5A5 then 0x5A5A5A5A -> two OUT reads return them in order. A third read returns 0 and sets bit30. Writing STATUS with 0xC0000000 clears both sticky bits.
- Full IN FIFO plus host write and app pop in the same cycle -> the host word is dropped, overflow is set, and the count goes to 15.
- WR held high through Reset deassertion -> no push and AppInValid stays 0. Reset asserted while RD is high on OUT -> no pop and the FIFO is empty after reset.
- Read at address 4 and write at address 5 -> DataOut=0 and no state change.

Source files
------------

// File: rtl/mailbox_pkg.sv
// Shared constants for the PBus host mailbox: register map, status layout, default widths.
package mailbox_pkg;

  localparam int unsigned GlobalDataWidth = 32;
  localparam int unsigned GlobalAddrWidth = 8;

  // Word addresses of the mailbox registers (Addr[1:0]).
  localparam logic [1:0] MB_IN      = 2'd0;
  localparam logic [1:0] MB_OUT     = 2'd1;
  localparam logic [1:0] MB_STATUS  = 2'd2;
  localparam logic [1:0] MB_SCRATCH = 2'd3;

  // Status register layout.
  localparam int unsigned OVF         = 31;
  localparam int unsigned UNF         = 30;
  localparam int unsigned CNT_IN_LSB  = 0;
  localparam int unsigned CNT_OUT_LSB = 8;
  localparam int unsigned CNT_FIELD_W = 8;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push while full or a pop while empty is ignored;
// fullness and emptiness are judged on the state at the start of the cycle.
module sync_fifo #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] dout,
  output logic [DepthLog2:0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned Depth = 1 << DepthLog2;
  localparam logic [DepthLog2:0] FullCount = {1'b1, {DepthLog2{1'b0}}};

  logic [DataWidth-1:0] mem [Depth];
  logic [DepthLog2-1:0] wptr_q, rptr_q;
  logic [DepthLog2:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr_q];
  assign count   = count_q;

  // Occupancy changes only when exactly one of push/pop takes effect.
  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= din;
  end

endmodule

// File: rtl/pbus_mailbox.sv
// Host mailbox between the PBus interface and application logic. Converts level-style host
// RD/WR transactions into single-cycle FIFO push/pop events and exposes valid/ready streams.
module pbus_mailbox
  import mailbox_pkg::*;
#(
  parameter int unsigned DataWidth = GlobalDataWidth,
  parameter int unsigned AddrWidth = GlobalAddrWidth,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [AddrWidth-1:0] Addr,
  input  logic [DataWidth-1:0] DataIn,
  output logic [DataWidth-1:0] DataOut,
  output logic [DataWidth-1:0] AppInData,
  output logic                 AppInValid,
  input  logic                 AppInReady,
  input  logic [DataWidth-1:0] AppOutData,
  input  logic                 AppOutValid,
  output logic                 AppOutReady
);

  logic                 rd_q, wr_q;
  logic                 armed_q, armed_d;
  logic [AddrWidth-1:0] addr_q;
  logic                 ovf_q, ovf_d, unf_q, unf_d;
  logic [DataWidth-1:0] scratch_q;
  logic [DataWidth-1:0] data_out_q, rdata;
  logic [DataWidth-1:0] status;

  logic rd_rise, wr_rise, wr_hit, rd_hit;
  logic host_push_req, host_pop_evt, status_we, scratch_we;
  logic in_pop, out_push;

  logic [DataWidth-1:0] in_dout, out_dout;
  logic [DepthLog2:0]   in_count, out_count;
  logic                 in_full, in_empty, out_full, out_empty;

  assign rd_rise = RD & ~rd_q;
  assign wr_rise = WR & ~wr_q;

  // Only the low two address bits select a register, and only if the rest are zero.
  assign wr_hit        = wr_rise & (Addr[AddrWidth-1:2] == '0);
  assign host_push_req = wr_hit & (Addr[1:0] == MB_IN);
  assign status_we     = wr_hit & (Addr[1:0] == MB_STATUS);
  assign scratch_we    = wr_hit & (Addr[1:0] == MB_SCRATCH);

  // OUT is popped after RD drops so the host has already sampled the head.
  assign host_pop_evt = armed_q & ~RD & (addr_q[AddrWidth-1:2] == '0) & (addr_q[1:0] == MB_OUT);

  assign in_pop   = AppInValid & AppInReady;
  assign out_push = AppOutValid & AppOutReady;

  assign AppInData   = in_dout;
  assign AppInValid  = ~in_empty;
  assign AppOutReady = ~out_full;
  assign DataOut     = data_out_q;

  sync_fifo #(
    .DataWidth (DataWidth),
    .DepthLog2 (DepthLog2)
  ) u_in_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (host_push_req),
    .pop   (in_pop),
    .din   (DataIn),
    .dout  (in_dout),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  sync_fifo #(
    .DataWidth (DataWidth),
    .DepthLog2 (DepthLog2)
  ) u_out_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (out_push),
    .pop   (host_pop_evt),
    .din   (AppOutData),
    .dout  (out_dout),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  // Read-armed flag: set on RD rise, cleared on the first RD-low cycle.
  always_comb begin
    armed_d = armed_q;
    if (rd_rise) begin
      armed_d = 1'b1;
    end else if (!RD) begin
      armed_d = 1'b0;
    end
  end

  // Sticky errors: a set in the same cycle beats a host clear.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (status_we && DataIn[OVF]) ovf_d = 1'b0;
    if (status_we && DataIn[UNF]) unf_d = 1'b0;
    if (host_push_req && in_full) ovf_d = 1'b1;
    if (host_pop_evt && out_empty) unf_d = 1'b1;
  end

  // Status word assembly.
  always_comb begin
    status = '0;
    status[OVF] = ovf_q;
    status[UNF] = unf_q;
    status[CNT_OUT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(out_count);
    status[CNT_IN_LSB +: CNT_FIELD_W]  = CNT_FIELD_W'(in_count);
  end

  // Read decode from the live address; unmapped addresses and IN read as zero.
  assign rd_hit = (Addr[AddrWidth-1:2] == '0);
  always_comb begin
    rdata = '0;
    if (RD && rd_hit) begin
      case (Addr[1:0])
        MB_OUT:     rdata = out_empty ? '0 : out_dout;
        MB_STATUS:  rdata = status;
        MB_SCRATCH: rdata = scratch_q;
        default:    rdata = '0;
      endcase
    end
  end

  // Host-side state. Strobe history resets high so a strobe held across reset is not an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_q       <= 1'b1;
      wr_q       <= 1'b1;
      armed_q    <= 1'b0;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      scratch_q  <= '0;
      data_out_q <= '0;
    end else begin
      rd_q       <= RD;
      wr_q       <= WR;
      armed_q    <= armed_d;
      if (rd_rise) addr_q <= Addr;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      if (scratch_we) scratch_q <= DataIn;
      data_out_q <= rdata;
    end
  end

endmodule

// File: tb/tb_pbus_mailbox.sv
// Directed self-checking bench for pbus_mailbox: a vector table for register-map accesses
// plus hand-written sequences for FIFO, sticky-error and reset corner cases.
module tb_pbus_mailbox;
  import mailbox_pkg::*;

  logic        Clk, Reset, RD, WR;
  logic [7:0]  Addr;
  logic [31:0] DataIn, DataOut, AppInData, AppOutData;
  logic        AppInValid, AppInReady, AppOutValid, AppOutReady;

  int n_checks = 0;
  int n_pass   = 0;

  pbus_mailbox #(
    .DataWidth (32),
    .AddrWidth (8),
    .DepthLog2 (4)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .RD          (RD),
    .WR          (WR),
    .Addr        (Addr),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .AppInData   (AppInData),
    .AppInValid  (AppInValid),
    .AppInReady  (AppInReady),
    .AppOutData  (AppOutData),
    .AppOutValid (AppOutValid),
    .AppOutReady (AppOutReady)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    Addr = a; DataIn = d; WR = 1'b1;
    tick(); tick();
    WR = 1'b0;
    tick();
  endtask

  // Returns DataOut as seen in the 2nd RD-high cycle.
  task automatic host_read(input logic [7:0] a, output logic [31:0] d);
    Addr = a; RD = 1'b1;
    tick();
    d = DataOut;
    tick();
    RD = 1'b0;
    tick(); tick();
  endtask

  logic [31:0] rd;

  initial begin
    Reset = 1'b1; RD = 1'b0; WR = 1'b0; Addr = '0; DataIn = '0;
    AppInReady = 1'b0; AppOutData = '0; AppOutValid = 1'b0;

    vecs[0]  = '{1'b1, 8'd3, 32'hDEADBEEF, 32'h0, "wr_scratch"};
    vecs[1]  = '{1'b0, 8'd3, 32'h0, 32'hDEADBEEF, "rd_scratch"};
    vecs[2]  = '{1'b0, 8'd2, 32'h0, 32'h00000000, "rd_status_reset"};
    vecs[3]  = '{1'b0, 8'd4, 32'h0, 32'h00000000, "rd_addr4"};
    vecs[4]  = '{1'b1, 8'd5, 32'h12345678, 32'h0, "wr_addr5"};
    vecs[5]  = '{1'b1, 8'd7, 32'h00000000, 32'h0, "wr_addr7"};
    vecs[6]  = '{1'b0, 8'd3, 32'h0, 32'hDEADBEEF, "rd_scratch_kept"};
    vecs[7]  = '{1'b0, 8'd2, 32'h0, 32'h00000000, "rd_status_kept"};
    vecs[8]  = '{1'b1, 8'd3, 32'h00001234, 32'h0, "wr_scratch2"};
    vecs[9]  = '{1'b0, 8'd3, 32'h0, 32'h00001234, "rd_scratch2"};
    vecs[10] = '{1'b0, 8'd6, 32'h0, 32'h00000000, "rd_addr6"};
    vecs[11] = '{1'b0, 8'd0, 32'h0, 32'h00000000, "rd_in_reg"};

    tick(); tick();
    Reset = 1'b0;
    tick();
    check("reset_dataout", DataOut, 32'h0);
    check("reset_appinvalid", {31'b0, AppInValid}, 32'h0);
    check("reset_appoutready", {31'b0, AppOutReady}, 32'h1);

    // Register-map table.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_wr) begin
        host_write(vecs[i].addr, vecs[i].data);
      end else begin
        host_read(vecs[i].addr, rd);
        check(vecs[i].name, rd, vecs[i].exp);
      end
    end
    check("dataout_idle", DataOut, 32'h0);

    // Fill IN with 1..16, then overflow.
    for (int i = 1; i <= 16; i++) host_write(8'd0, 32'(i));
    check("in_valid_after_fill", {31'b0, AppInValid}, 32'h1);
    host_read(8'd2, rd);
    check("status_in16", rd, 32'h00000010);
    host_write(8'd0, 32'd17);
    host_read(8'd2, rd);
    check("status_ovf", rd, 32'h80000010);
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("app_pop_%0d", i), AppInData, 32'(i));
      AppInReady = 1'b1;
      tick();
      AppInReady = 1'b0;
    end
    check("in_empty_after_drain", {31'b0, AppInValid}, 32'h0);
    host_write(8'd2, 32'h80000000);
    host_read(8'd2, rd);
    check("status_ovf_cleared", rd, 32'h00000000);

    // App pushes two words; host reads them then underflows.
    AppOutValid = 1'b1; AppOutData = 32'hA5A5A5A5;
    tick();
    AppOutData = 32'h5A5A5A5A;
    tick();
    AppOutValid = 1'b0;
    host_read(8'd2, rd);
    check("status_out2", rd, 32'h00000200);
    host_read(8'd1, rd);
    check("out_rd1", rd, 32'hA5A5A5A5);
    host_read(8'd1, rd);
    check("out_rd2", rd, 32'h5A5A5A5A);
    host_read(8'd1, rd);
    check("out_rd_empty", rd, 32'h0);
    host_read(8'd2, rd);
    check("status_unf", rd, 32'h40000000);
    host_write(8'd2, 32'hC0000000);
    host_read(8'd2, rd);
    check("status_unf_cleared", rd, 32'h00000000);

    // Full IN with simultaneous host write and app pop.
    for (int i = 1; i <= 16; i++) host_write(8'd0, 32'h200 + 32'(i));
    Addr = 8'd0; DataIn = 32'h00000BAD; WR = 1'b1; AppInReady = 1'b1;
    tick();
    AppInReady = 1'b0;
    tick();
    WR = 1'b0;
    tick();
    host_read(8'd2, rd);
    check("status_full_push_pop", rd, 32'h8000000F);
    for (int i = 2; i <= 16; i++) begin
      check($sformatf("drop_pop_%0d", i), AppInData, 32'h200 + 32'(i));
      AppInReady = 1'b1;
      tick();
      AppInReady = 1'b0;
    end
    check("in_empty_no_bad", {31'b0, AppInValid}, 32'h0);
    host_write(8'd2, 32'h80000000);

    // Fill OUT to see AppOutReady drop after the filling push.
    AppOutValid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      AppOutData = 32'h100 + 32'(i);
      tick();
      if (i == 15) check("out_ready_at15", {31'b0, AppOutReady}, 32'h1);
    end
    AppOutValid = 1'b0;
    check("out_ready_full", {31'b0, AppOutReady}, 32'h0);
    host_read(8'd2, rd);
    check("status_out16", rd, 32'h00001000);

    // Reset during an OUT read: aborted, FIFO empty afterwards.
    Addr = 8'd1; RD = 1'b1;
    tick(); tick();
    Reset = 1'b1;
    tick();
    RD = 1'b0;
    tick();
    Reset = 1'b0;
    tick(); tick();
    check("rst_rd_out_ready", {31'b0, AppOutReady}, 32'h1);
    check("rst_rd_dataout", DataOut, 32'h0);
    host_read(8'd2, rd);
    check("rst_rd_status", rd, 32'h00000000);

    // WR held high across reset release: no push.
    Reset = 1'b1; Addr = 8'd0; DataIn = 32'h77; WR = 1'b1;
    tick();
    Reset = 1'b0;
    tick(); tick();
    check("rst_wr_no_valid", {31'b0, AppInValid}, 32'h0);
    WR = 1'b0;
    tick();
    check("rst_wr_no_valid2", {31'b0, AppInValid}, 32'h0);
    host_read(8'd2, rd);
    check("rst_wr_status", rd, 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
